// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg: shared definitions for the cache/memory arbiter.
//   SIZE_*       access size encodings on req_size / mem_size
//   arb_state_e  arbiter FSM states
package cache_arb_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational winner select.
//   req    in   NUM_CH  request vector
//   start  in   CW      first index searched; search wraps NUM_CH-1 -> 0
//   valid  out  1       at least one request present
//   idx    out  CW      index of first requester at or after start
module arb_pick
  import cache_arb_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CW     = 3
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CW-1:0]     start,
  output logic              valid,
  output logic [CW-1:0]     idx
);

  always_comb begin
    int unsigned cand;
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = (32'(start) + i) % NUM_CH;
      // Compare against each constant index rather than indexing by cand.
      for (int unsigned j = 0; j < NUM_CH; j++) begin
        if (!valid && (j == cand) && req[j]) begin
          valid = 1'b1;
          idx   = CW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: N-channel arbiter between cache refill/write ports and
// the single axi_interface cache port. Registered grant, latched command,
// one outstanding transaction.
//   Config macro ARB_ROUND_ROBIN_EN: defined -> round-robin priority with rr
//   pointer; undefined -> fixed priority (channel 0 highest).
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_access/write/addr/size/  per-channel packed requests (ch i at [i*W +: W])
//   sel/wdata
//   req_ready                    one-hot completion pulse to granted channel
//   req_rdata                    read data, pass-through of mem_data
//   mem_a/access/write/size/     latched command to axi_interface
//   sel/st_data
//   mem_data, mem_ready          response from axi_interface
//   busy                         transaction outstanding
//   gnt_idx                      index of current/last grant
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned CW     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    req_access,
  input  logic [NUM_CH-1:0]    req_write,
  input  logic [NUM_CH*AW-1:0] req_addr,
  input  logic [NUM_CH*2-1:0]  req_size,
  input  logic [NUM_CH*4-1:0]  req_sel,
  input  logic [NUM_CH*DW-1:0] req_wdata,
  output logic [NUM_CH-1:0]    req_ready,
  output logic [DW-1:0]        req_rdata,
  output logic [AW-1:0]        mem_a,
  output logic                 mem_access,
  output logic                 mem_write,
  output logic [1:0]           mem_size,
  output logic [3:0]           mem_sel,
  output logic [DW-1:0]        mem_st_data,
  input  logic [DW-1:0]        mem_data,
  input  logic                 mem_ready,
  output logic                 busy,
  output logic [CW-1:0]        gnt_idx
);

  arb_state_e     state_q, state_d;
  logic [AW-1:0]  mem_a_q, mem_a_d;
  logic           mem_write_q, mem_write_d;
  logic [1:0]     mem_size_q, mem_size_d;
  logic [3:0]     mem_sel_q, mem_sel_d;
  logic [DW-1:0]  mem_st_data_q, mem_st_data_d;
  logic [CW-1:0]  gnt_idx_q, gnt_idx_d;

  logic [CW-1:0]  start_idx;
  logic           win_valid;
  logic [CW-1:0]  win_idx;

`ifdef ARB_ROUND_ROBIN_EN
  logic [CW-1:0]  rr_q, rr_d;
  assign start_idx = rr_q;
`else
  assign start_idx = '0;
`endif

  arb_pick #(
    .NUM_CH (NUM_CH),
    .CW     (CW)
  ) u_pick (
    .req   (req_access),
    .start (start_idx),
    .valid (win_valid),
    .idx   (win_idx)
  );

  always_comb begin
    state_d       = state_q;
    mem_a_d       = mem_a_q;
    mem_write_d   = mem_write_q;
    mem_size_d    = mem_size_q;
    mem_sel_d     = mem_sel_q;
    mem_st_data_d = mem_st_data_q;
    gnt_idx_d     = gnt_idx_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_d          = rr_q;
`endif
    unique case (state_q)
      ARB_IDLE: begin
        if (win_valid) begin
          state_d   = ARB_BUSY;
          gnt_idx_d = win_idx;
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (CW'(i) == win_idx) begin
              mem_a_d       = req_addr[i*AW +: AW];
              mem_write_d   = req_write[i];
              mem_size_d    = req_size[i*2 +: 2];
              mem_sel_d     = req_sel[i*4 +: 4];
              mem_st_data_d = req_wdata[i*DW +: DW];
            end
          end
`ifdef ARB_ROUND_ROBIN_EN
          rr_d = (win_idx == CW'(NUM_CH - 1)) ? '0 : win_idx + CW'(1);
`endif
        end
      end
      ARB_BUSY: begin
        // Requester inputs are ignored here; only mem_ready ends the transaction.
        if (mem_ready) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      mem_a_q       <= '0;
      mem_write_q   <= 1'b0;
      mem_size_q    <= '0;
      mem_sel_q     <= '0;
      mem_st_data_q <= '0;
      gnt_idx_q     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q          <= '0;
`endif
    end else begin
      state_q       <= state_d;
      mem_a_q       <= mem_a_d;
      mem_write_q   <= mem_write_d;
      mem_size_q    <= mem_size_d;
      mem_sel_q     <= mem_sel_d;
      mem_st_data_q <= mem_st_data_d;
      gnt_idx_q     <= gnt_idx_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q          <= rr_d;
`endif
    end
  end

  // Completion pulse is combinational so the cache sees it with mem_data.
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      req_ready[i] = (state_q == ARB_BUSY) && mem_ready && (gnt_idx_q == CW'(i));
    end
  end

  assign req_rdata   = mem_data;
  assign mem_a       = mem_a_q;
  assign mem_access  = (state_q == ARB_BUSY);
  assign mem_write   = mem_write_q;
  assign mem_size    = mem_size_q;
  assign mem_sel     = mem_sel_q;
  assign mem_st_data = mem_st_data_q;
  assign busy        = (state_q == ARB_BUSY);
  assign gnt_idx     = gnt_idx_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_access, req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*2-1:0]  req_size;
  logic [N*4-1:0]  req_sel;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   req_rdata;
  logic [AW-1:0]   mem_a;
  logic            mem_access, mem_write;
  logic [1:0]      mem_size;
  logic [3:0]      mem_sel;
  logic [DW-1:0]   mem_st_data, mem_data;
  logic            mem_ready, busy;
  logic [CW-1:0]   gnt_idx;

  int n_checks = 0;
  int n_pass   = 0;
  int rr_ptr   = 0;

  cache_mem_arbiter #(.NUM_CH(N), .AW(AW), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .req_access(req_access), .req_write(req_write), .req_addr(req_addr),
    .req_size(req_size), .req_sel(req_sel), .req_wdata(req_wdata),
    .req_ready(req_ready), .req_rdata(req_rdata),
    .mem_a(mem_a), .mem_access(mem_access), .mem_write(mem_write),
    .mem_size(mem_size), .mem_sel(mem_sel), .mem_st_data(mem_st_data),
    .mem_data(mem_data), .mem_ready(mem_ready),
    .busy(busy), .gnt_idx(gnt_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: first requester at or after the pointer, wrapping.
  function automatic int model_pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic void model_granted(input int w);
`ifdef ARB_ROUND_ROBIN_EN
    rr_ptr = (w + 1) % N;
`else
    rr_ptr = 0;
`endif
  endfunction

  task automatic clear_inputs();
    req_access = '0; req_write = '0; req_addr = '0; req_size = '0;
    req_sel = '0; req_wdata = '0; mem_data = '0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    rr_ptr = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({busy, mem_access, mem_write, mem_a, mem_size, mem_sel, mem_st_data, req_ready, gnt_idx} !== '0)
      $display("FAIL reset_state: busy=%b acc=%b wr=%b a=%h sz=%h sel=%h sd=%h rdy=%b gnt=%0d, required all zero",
               busy, mem_access, mem_write, mem_a, mem_size, mem_sel, mem_st_data, req_ready, gnt_idx);
    else n_pass++;
  endtask

  task automatic test_single_read();
    do_reset();
    req_access = 2'b01; req_addr[31:0] = 32'h1fc0_0000; req_size[1:0] = 2'b10; req_sel[3:0] = 4'hf;
    #1;
    n_checks++;
    if (mem_access !== 1'b0) $display("FAIL sr_no_early_access: got %b required 0", mem_access); else n_pass++;
    tick();
    n_checks++;
    if (mem_access !== 1'b1 || mem_a !== 32'h1fc0_0000 || busy !== 1'b1 || mem_write !== 1'b0)
      $display("FAIL sr_grant: acc=%b a=%h busy=%b wr=%b required 1 1fc00000 1 0", mem_access, mem_a, busy, mem_write);
    else n_pass++;
    tick(); tick();
    n_checks++;
    if (req_ready !== 2'b00) $display("FAIL sr_no_early_ready: got %b required 00", req_ready); else n_pass++;
    mem_ready = 1'b1; mem_data = 32'hdeadbeef;
    #1;
    n_checks++;
    if (req_ready !== 2'b01 || req_rdata !== 32'hdeadbeef)
      $display("FAIL sr_complete: rdy=%b rdata=%h required 01 deadbeef", req_ready, req_rdata);
    else n_pass++;
    tick();
    req_access = '0; mem_ready = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || mem_access !== 1'b0 || req_ready !== 2'b00)
      $display("FAIL sr_idle_after: busy=%b acc=%b rdy=%b required 0 0 00", busy, mem_access, req_ready);
    else n_pass++;
  endtask

  task automatic test_priority();
    do_reset();
    req_access = 2'b11;
    req_addr = {32'h0000_2000, 32'h0000_1000};
    tick();
    n_checks++;
    if (gnt_idx !== 3'd0 || mem_a !== 32'h0000_1000)
      $display("FAIL prio_first: gnt=%0d a=%h required 0 00001000", gnt_idx, mem_a);
    else n_pass++;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; req_access = 2'b10;
    #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL prio_idle_gap: busy=%b required 0", busy); else n_pass++;
    tick();
    n_checks++;
    if (busy !== 1'b1 || gnt_idx !== 3'd1 || mem_a !== 32'h0000_2000)
      $display("FAIL prio_second: busy=%b gnt=%0d a=%h required 1 1 00002000", busy, gnt_idx, mem_a);
    else n_pass++;
    mem_ready = 1'b1;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_both_held();
    logic [CW-1:0] exp [4];
`ifdef ARB_ROUND_ROBIN_EN
    exp = '{3'd0, 3'd1, 3'd0, 3'd1};
`else
    exp = '{3'd0, 3'd0, 3'd0, 3'd0};
`endif
    do_reset();
    req_access = 2'b11;
    for (int t = 0; t < 4; t++) begin
      tick();
      n_checks++;
      if (gnt_idx !== exp[t] || busy !== 1'b1)
        $display("FAIL held_order_%0d: gnt=%0d busy=%b required %0d 1", t, gnt_idx, busy, exp[t]);
      else n_pass++;
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_write_hold();
    do_reset();
    req_access = 2'b10; req_write = 2'b10;
    req_addr[63:32] = 32'h8000_0010; req_sel[7:4] = 4'b0011;
    req_wdata[63:32] = 32'h1234_5678; req_size[3:2] = 2'b01;
    tick();
    req_write = 2'b00; req_addr[63:32] = 32'hffff_ffff; req_sel[7:4] = 4'b1100;
    req_wdata[63:32] = 32'h0; req_size[3:2] = 2'b00;
    for (int t = 0; t < 3; t++) begin
      #1;
      n_checks++;
      if (mem_access !== 1'b1 || mem_write !== 1'b1 || mem_a !== 32'h8000_0010 ||
          mem_sel !== 4'b0011 || mem_st_data !== 32'h1234_5678 || mem_size !== 2'b01 || gnt_idx !== 3'd1)
        $display("FAIL wr_hold_%0d: acc=%b wr=%b a=%h sel=%b sd=%h sz=%b gnt=%0d required 1 1 80000010 0011 12345678 01 1",
                 t, mem_access, mem_write, mem_a, mem_sel, mem_st_data, mem_size, gnt_idx);
      else n_pass++;
      tick();
    end
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 2'b10) $display("FAIL wr_ready: got %b required 10", req_ready); else n_pass++;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_drop_req();
    do_reset();
    req_access = 2'b01; req_addr[31:0] = 32'h0000_0040;
    tick();
    req_access = '0;
    tick(); tick();
    n_checks++;
    if (mem_access !== 1'b1 || busy !== 1'b1)
      $display("FAIL drop_held: acc=%b busy=%b required 1 1", mem_access, busy);
    else n_pass++;
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) $display("FAIL drop_ready: got %b required 01", req_ready); else n_pass++;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_access = 2'b01; req_addr[31:0] = 32'h0000_0080;
    tick();
    req_access = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rr_ptr = 0;
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || mem_access !== 1'b0 || req_ready !== 2'b00 || mem_a !== 32'h0)
      $display("FAIL rst_mid: busy=%b acc=%b rdy=%b a=%h required 0 0 00 0", busy, mem_access, req_ready, mem_a);
    else n_pass++;
    tick();
    n_checks++;
    if (busy !== 1'b0 || req_ready !== 2'b00)
      $display("FAIL idle_ready_ignored: busy=%b rdy=%b required 0 00", busy, req_ready);
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_random();
    int w, lat;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d, rd;
    logic [1:0] e_sz;
    logic [3:0] e_sel;
    logic e_wr;
    logic [N-1:0] r;
    do_reset();
    for (int t = 0; t < 60; t++) begin
      r = N'($urandom_range(1, (1 << N) - 1));
      req_access = r;
      req_write = N'($urandom);
      for (int c = 0; c < N; c++) begin
        req_addr[c*AW +: AW] = $urandom;
        req_wdata[c*DW +: DW] = $urandom;
        req_size[c*2 +: 2] = 2'($urandom_range(0, 2));
        req_sel[c*4 +: 4] = 4'($urandom);
      end
      mem_ready = 1'($urandom);
      mem_data = $urandom;
      w = model_pick(r, rr_ptr);
      e_a = req_addr[w*AW +: AW]; e_d = req_wdata[w*DW +: DW];
      e_sz = req_size[w*2 +: 2]; e_sel = req_sel[w*4 +: 4]; e_wr = req_write[w];
      #1;
      n_checks++;
      if (req_ready !== '0 || busy !== 1'b0)
        $display("FAIL rnd_idle_%0d: rdy=%b busy=%b required 0 0", t, req_ready, busy);
      else n_pass++;
      tick();
      model_granted(w);
      n_checks++;
      if (busy !== 1'b1 || gnt_idx !== CW'(w) || mem_a !== e_a || mem_st_data !== e_d ||
          mem_size !== e_sz || mem_sel !== e_sel || mem_write !== e_wr)
        $display("FAIL rnd_grant_%0d: gnt=%0d a=%h sd=%h sz=%b sel=%b wr=%b required %0d %h %h %b %b %b",
                 t, gnt_idx, mem_a, mem_st_data, mem_size, mem_sel, mem_write, w, e_a, e_d, e_sz, e_sel, e_wr);
      else n_pass++;
      lat = $urandom_range(0, 3);
      mem_ready = 1'b0;
      for (int k = 0; k < lat; k++) begin
        req_access = N'($urandom);
        req_addr = {N{32'($urandom)}};
        #1;
        n_checks++;
        if (req_ready !== '0 || mem_a !== e_a)
          $display("FAIL rnd_wait_%0d: rdy=%b a=%h required 0 %h", t, req_ready, mem_a, e_a);
        else n_pass++;
        tick();
      end
      rd = $urandom;
      mem_data = rd;
      mem_ready = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== N'(1 << w) || req_rdata !== rd)
        $display("FAIL rnd_done_%0d: rdy=%b rdata=%h required %b %h", t, req_ready, req_rdata, N'(1 << w), rd);
      else n_pass++;
      tick();
      req_access = '0;
      mem_ready = 1'b0;
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_priority();
    test_both_held();
    test_write_hold();
    test_drop_req();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
